// File: rtl/if_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_unit
//  Brief    : Instruction-fetch unit. It has an 8-bit program counter with
//             sequential/jump selection and a 256 x 20 instruction memory
//             with a combinational read port and a synchronous load port.
//  Revision : 1.0 - initial release
// ============================================================================
module if_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_selector,
    input  logic [7:0]  jump_address,
    output logic [19:0] ci,
    output logic [7:0]  npc,
    input  logic        imem_we,
    input  logic [7:0]  imem_waddr,
    input  logic [19:0] imem_wdata
);

    localparam int unsigned C_AW    = 8;
    localparam int unsigned C_IW    = 20;
    localparam int unsigned C_DEPTH = 1 << C_AW;

    logic [C_AW-1:0] pc_q;
    logic [C_AW-1:0] pc_d;
    logic [C_IW-1:0] imem_q [C_DEPTH];

    // Sequential successor; the 8-bit add wraps 255 to 0 naturally.
    assign npc = pc_q + 8'd1;

    // Fetch is asynchronous, so ci follows PC within the same cycle.
    assign ci = imem_q[pc_q];

    // Next-PC select: the jump target is consulted only when the selector is
    // high, so an undriven jump_address cannot leak into the PC path.
    always_comb begin
        pc_d = npc;
        if (jump_selector) begin
            pc_d = jump_address;
        end
    end

    // PC register: asynchronous reset to address 0 overrides any pending jump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Program-load port: it is independent of reset so that a program can be
    // loaded while the core is held in reset. The contents are never cleared.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_unit
//  Brief    : Directed self-checking bench for if_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_unit;

    logic        clk;
    logic        rst_n;
    logic        jump_selector;
    logic [7:0]  jump_address;
    logic [19:0] ci;
    logic [7:0]  npc;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [19:0] imem_wdata;

    int tests;
    int fails;

    if_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_selector (jump_selector),
        .jump_address  (jump_address),
        .ci            (ci),
        .npc           (npc),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        jump_selector = 1'b0;
        jump_address  = 8'd0;
        imem_we       = 1'b0;
        imem_waddr    = 8'd0;
        imem_wdata    = 20'd0;

        // Preload imem[k] = k + 100 while reset is held.
        #1;
        for (int k = 0; k < 256; k++) begin
            imem_we    = 1'b1;
            imem_waddr = k[7:0];
            imem_wdata = 20'(k + 100);
            step();
        end
        imem_we = 1'b0;

        // Reset state
        check("rst_npc", 32'(npc), 32'd1);
        check("rst_ci",  32'(ci),  32'd100);

        // Reset holds PC at 0 even with a jump requested.
        jump_selector = 1'b1;
        jump_address  = 8'd50;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold_npc", 32'(npc), 32'd1);
        end
        check("rst_hold_ci", 32'(ci), 32'd100);

        // Release reset between edges and fetch sequentially.
        jump_selector = 1'b0;
        rst_n         = 1'b1;
        step();
        check("seq1_npc", 32'(npc), 32'd2);
        step();
        step();
        step();
        check("seq4_npc", 32'(npc), 32'd5);
        check("seq4_ci",  32'(ci),  32'd104);

        // Jump to 12, hold for two more edges, then resume sequential fetch.
        jump_address  = 8'd12;
        jump_selector = 1'b1;
        step();
        check("jmp_npc", 32'(npc), 32'd13);
        check("jmp_ci",  32'(ci),  32'd112);
        step();
        step();
        check("jmp_hold_npc", 32'(npc), 32'd13);
        jump_selector = 1'b0;
        step();
        check("jmp_clr_npc", 32'(npc), 32'd14);
        check("jmp_clr_ci",  32'(ci),  32'd113);

        // Wrap at 255.
        jump_address  = 8'd255;
        jump_selector = 1'b1;
        step();
        check("wrap_npc", 32'(npc), 32'd0);
        check("wrap_ci",  32'(ci),  32'd355);
        jump_selector = 1'b0;
        step();
        check("wrap_next_npc", 32'(npc), 32'd1);
        check("wrap_next_ci",  32'(ci),  32'd100);

        // Asynchronous reset mid-run at PC=40.
        jump_address  = 8'd40;
        jump_selector = 1'b1;
        step();
        check("pc40_npc", 32'(npc), 32'd41);
        check("pc40_ci",  32'(ci),  32'd140);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_npc", 32'(npc), 32'd1);
        check("async_rst_ci",  32'(ci),  32'd100);

        // X on jump_address must be ignored when the selector is low.
        step();
        jump_selector = 1'b0;
        jump_address  = 8'bx;
        rst_n         = 1'b1;
        step();
        check("xaddr_npc", 32'(npc), 32'd2);
        check("xaddr_ci",  32'(ci),  32'd101);

        // Jump to the current PC keeps it unchanged.
        jump_address  = 8'd1;
        jump_selector = 1'b1;
        step();
        check("self_jmp_npc", 32'(npc), 32'd2);

        // Load while PC is held at 7: write-then-read, no same-cycle bypass.
        jump_address = 8'd7;
        step();
        check("pc7_ci", 32'(ci), 32'd107);
        imem_we    = 1'b1;
        imem_waddr = 8'd7;
        imem_wdata = 20'hABCDE;
        #1;
        check("load_pre_ci", 32'(ci), 32'd107);
        step();
        check("load_ci",  32'(ci),  32'hABCDE);
        check("load_npc", 32'(npc), 32'd8);

        // Write to the next address while PC advances onto it in the same edge.
        jump_selector = 1'b0;
        imem_waddr    = 8'd8;
        imem_wdata    = 20'h12345;
        step();
        imem_we = 1'b0;
        check("load_adv_ci",  32'(ci),  32'h12345);
        check("load_adv_npc", 32'(npc), 32'd9);
        step();
        check("load_other_ci", 32'(ci), 32'd109);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 Parameters: none; address width fixed at 8 bits, instruction width fixed at 20 bits.
REQ-002 One clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 jump_selector  input  1  1 = next PC is jump_address; 0 = next PC is PC+1.
REQ-006 jump_address  input  8  branch/jump target address.
REQ-007 ci  output  20  current instruction, i.e. imem[PC].
REQ-008 npc  output  8  next sequential address, PC+1.
REQ-009 imem_we  input  1  instruction-memory write enable (program load).
REQ-010 imem_waddr  input  8  instruction-memory write address.
REQ-011 imem_wdata  input  20  instruction-memory write data.
REQ-012 Positional port order: clk, rst_n, jump_selector, jump_address, ci, npc, imem_we, imem_waddr, imem_wdata.

Function
REQ-013 Internal 8-bit program counter register PC.
REQ-014 Internal instruction memory: 256 words x 20 bits, indexed by address 0..255.
REQ-015 npc = (PC + 1) mod 256, combinational; 255 wraps to 0.
REQ-016 ci = imem[PC], asynchronous (combinational) read; changes in the same cycle PC changes.
REQ-017 On each rising clk edge with rst_n=1: PC <= jump_address if jump_selector=1, else PC <= npc.
REQ-018 jump_selector and jump_address are sampled only at the rising edge; no other effect.
REQ-019 Jump held high for several cycles reloads jump_address every edge; PC stays at the target.
REQ-020 Jump to the current PC value is legal; PC remains unchanged.
REQ-021 On a rising edge with imem_we=1: imem[imem_waddr] <= imem_wdata; PC update proceeds independently in the same edge.
REQ-022 Write to address == PC: ci shows the new word after the edge (write-then-read, no bypass within the cycle).
REQ-023 Memory write is not gated by rst_n; writes occur whenever imem_we=1 at a rising edge, including during reset.
REQ-024 Memory contents are not cleared by reset; they are undefined until written.
REQ-025 No X propagation from jump_address when jump_selector=0; the PC path ignores it.

Reset
REQ-026 rst_n=0 asynchronously forces PC=0 immediately, independent of clk.
REQ-027 While in reset: npc=1, ci=imem[0]; PC held at 0 across clock edges.
REQ-028 First rising edge after rst_n deasserts performs a normal update (PC to 1 or jump target).
REQ-029 Reset asserted mid-run overrides any pending jump; PC=0 regardless of jump_selector.

Verification
REQ-030 Reset: preload imem[k]=k+100 for all k, rst_n=0 -> PC=0, npc=1, ci=100; npc stays 1 over 3 clock edges.
REQ-031 Sequential: release reset, jump_selector=0, 4 edges -> npc=5, ci=104.
REQ-032 Jump: at npc=5, set jump_address=12, jump_selector=1, 1 edge -> npc=13, ci=112; hold 2 more edges -> npc stays 13; clear selector, 1 edge -> npc=14.
REQ-033 Wrap: jump to 255 -> npc=0, ci=imem[255]; next edge with selector=0 -> PC=0, npc=1.
REQ-034 Async reset: at PC=40, drop rst_n between edges -> npc=1 immediately, before the next clock edge.
REQ-035 Load: write imem[7]=20'hABCDE while PC=7 -> ci=20'hABCDE after that edge if PC is held at 7 via jump to 7.
